// File: rtl/shift_add_seq_pkg.sv
// Shared definitions for the radix-2 Booth multiplier slice: FSM state
// encodings, iteration count, Booth select codes and a range helper.
package shift_add_seq_pkg;

    // Number of shift iterations; equals the operand width.
    localparam int ITER_DEFAULT = 4;

    // Width of the iteration counter (holds 0 .. ITER_DEFAULT-1).
    localparam int CNT_W = 2;

    // Width of the FSM state register.
    localparam int STATE_W = 2;

    // FSM state encodings.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Booth select codes, taken from {q[1], q[0]} = {Q0, Q-1}.
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    // Most negative 4-bit value; its negation does not fit in the
    // 4-bit accumulator, so the result is flagged instead.
    localparam logic [3:0] M_MIN = 4'b1000;

    // True when the multiplicand cannot be handled by a 4-bit accumulator.
    function automatic logic is_range_err(input logic [3:0] m);
        return (m == M_MIN);
    endfunction

endpackage

// File: rtl/shift_add_seq_booth_addsub.sv
// Combinational Booth add/subtract stage. Produces the new upper nibble of
// the partial product: a + b, a - b, or a unchanged, chosen by the Booth
// select pair. All arithmetic wraps modulo 2^4.
module booth_addsub
    import shift_add_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    // Select add, subtract or pass-through from the Booth bit pair.
    always_comb begin
        y = a;
        case (sel)
            BOOTH_ADD:  y = a + b;
            BOOTH_SUB:  y = a - b;
            BOOTH_NOP0: y = a;
            BOOTH_NOP1: y = a;
            default:    y = a;
        endcase
    end

endmodule

// File: rtl/shift_add_seq.sv
// Sequencer for a 4x4 signed Booth multiplier built around an external
// 9-bit right-shift register q = {A[3:0], Q[3:0], Q-1}.
//
// Flow: IDLE --start--> LOAD (1 cycle, load=1) --> SHIFT (ITER cycles)
//       --> DONE (1 cycle) --> IDLE, with done pulsing in the cycle after
//       DONE. The shift register loads on the LOAD edge and shifts on each
//       SHIFT edge, taking adder_result as its new upper nibble.
//
// Handshake: start is a request sampled only in IDLE; the accepting edge
// captures the multiplicand. There is no back-pressure and no queuing:
// start while busy is dropped. done is a one-cycle valid strobe; product
// and range_err stay stable from that cycle until the next done.
//
// state_dbg mirrors the FSM state for observation only.
module shift_add_seq
    import shift_add_seq_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] multiplicand,
    input  logic [8:0] q,
    output logic       load,
    output logic [3:0] adder_result,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic       range_err,
    output logic [1:0] state_dbg
);

    // Last SHIFT count value; reaching it ends the SHIFT phase.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         m_reg;
    logic [1:0]         booth_sel;
    logic [3:0]         addsub_y;
    logic               in_shift;

    assign in_shift = (state == S_SHIFT);

    // Next-state decode for the Moore FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter: cleared in LOAD, advances once per SHIFT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_LOAD) begin
            cnt <= '0;
        end else if (in_shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Multiplicand capture, only on the edge that accepts start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg <= '0;
        end else if ((state == S_IDLE) && start) begin
            m_reg <= multiplicand;
        end
    end

    // Booth select is forced to pass-through outside SHIFT so the upper
    // nibble is presented unchanged.
    always_comb begin
        booth_sel = BOOTH_NOP0;
        if (in_shift) begin
            booth_sel = q[1:0];
        end
    end

    booth_addsub u_addsub (
        .a   (q[8:5]),
        .b   (m_reg),
        .sel (booth_sel),
        .y   (addsub_y)
    );

    assign adder_result = addsub_y;

    // Moore output decode.
    assign load      = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Result registers: done pulses for the cycle after DONE; product and
    // range_err update only on the DONE edge and then hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            product   <= 8'h00;
            range_err <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                range_err <= is_range_err(m_reg);
                product   <= is_range_err(m_reg) ? 8'h00 : q[8:1];
            end
        end
    end

endmodule
